// File: rtl/fp_add_arbiter_if.sv
// Bundle for the arbiter: requester valid/ready with packed operands, the
// shared adder's go/operand/result, the response stream and busy.
interface fp_add_arbiter_if #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
);
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [32*N-1:0] req_a;
    logic [32*N-1:0] req_b;

    logic            adder_go;
    logic [31:0]     adder_a;
    logic [31:0]     adder_b;
    logic [31:0]     adder_result;

    logic            resp_valid;
    logic            resp_ready;
    logic [31:0]     resp_data;
    logic [IDW-1:0]  resp_id;
    logic            busy;

    // The arbiter itself.
    modport slave (
        input  req_valid, req_a, req_b, adder_result, resp_ready,
        output req_ready, adder_go, adder_a, adder_b,
               resp_valid, resp_data, resp_id, busy
    );

    // Requesters, adder and response consumer taken together.
    modport master (
        output req_valid, req_a, req_b, adder_result, resp_ready,
        input  req_ready, adder_go, adder_a, adder_b,
               resp_valid, resp_data, resp_id, busy
    );
endinterface

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one stall-free pipelined FP adder among N requesters.
// A tag pipe follows each op through the adder; credits keep the response FIFO from overflowing.
module fp_add_arbiter #(
    parameter int N          = 4,
    parameter int LATENCY    = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int IDW        = $clog2(N)
) (
    input logic             clk,
    input logic             reset,
    fp_add_arbiter_if.slave bus
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [31:0]    data;
    } entry_t;

    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [LATENCY-1:0] tag_valid_q, tag_valid_d;
    logic [IDW-1:0]     tag_id_q [LATENCY];
    logic [IDW-1:0]     tag_id_d [LATENCY];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [CW-1:0]      credits_q, credits_d;
    entry_t             mem_q [FIFO_DEPTH];

    logic [2*N-1:0]     req_dbl;
    logic [N-1:0]       req_rot;
    int                 grant_off;
    int                 grant_sum;
    logic [IDW-1:0]     grant;
    logic               issue;
    logic               push;
    logic               pop;
    logic               fifo_empty;
    entry_t             head;

    // Rotate the request vector so rr_ptr lands at bit 0; the lowest set bit wins.
    always_comb begin
        // NOTE: every variable gets a value before any branch, so no latch is inferred.
        req_dbl   = {bus.req_valid, bus.req_valid} >> rr_ptr_q;
        req_rot   = req_dbl[N-1:0];
        grant_off = 0;
        for (int j = N - 1; j >= 0; j--) begin
            if (req_rot[j]) grant_off = j;
        end
        grant_sum = int'(rr_ptr_q) + grant_off;
        grant     = IDW'((grant_sum >= N) ? grant_sum - N : grant_sum);
        issue     = !reset && (|bus.req_valid) && (credits_q != '0);
    end

    always_comb begin
        bus.req_ready = '0;
        bus.adder_a   = '0;
        bus.adder_b   = '0;
        bus.adder_go  = issue;
        for (int i = 0; i < N; i++) begin
            if (issue && grant == IDW'(i)) begin
                bus.req_ready[i] = 1'b1;
                bus.adder_a      = bus.req_a[32*i +: 32];
                bus.adder_b      = bus.req_b[32*i +: 32];
            end
        end
    end

    always_comb begin
        push       = tag_valid_q[LATENCY-1];
        fifo_empty = (count_q == '0);
        pop        = !fifo_empty && bus.resp_ready;

        rr_ptr_d = rr_ptr_q;
        if (issue) rr_ptr_d = (grant == IDW'(N - 1)) ? '0 : grant + IDW'(1);

        tag_valid_d[0] = issue;
        tag_id_d[0]    = grant;
        for (int k = 1; k < LATENCY; k++) begin
            tag_valid_d[k] = tag_valid_q[k-1];
            tag_id_d[k]    = tag_id_q[k-1];
        end

        wr_ptr_d = wr_ptr_q;
        if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
        rd_ptr_d = rd_ptr_q;
        if (pop) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);

        count_d = count_q + CW'(push) - CW'(pop);
        // A pop returns its credit only at the next edge; no same-cycle bypass.
        credits_d = credits_q - CW'(issue) + CW'(pop);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            rr_ptr_q    <= '0;
            tag_valid_q <= '0;
            for (int k = 0; k < LATENCY; k++) tag_id_q[k] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            credits_q   <= DEPTH_C;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            tag_valid_q <= tag_valid_d;
            for (int k = 0; k < LATENCY; k++) tag_id_q[k] <= tag_id_d[k];
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            credits_q   <= credits_d;
        end
    end

    // NOTE: storage is not reset; the head is masked to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{id: tag_id_q[LATENCY-1], data: bus.adder_result};
    end

    always_comb begin
        head           = mem_q[rd_ptr_q];
        bus.resp_valid = !fifo_empty;
        bus.resp_data  = fifo_empty ? '0 : head.data;
        bus.resp_id    = fifo_empty ? '0 : head.id;
        bus.busy       = (|tag_valid_q) || !fifo_empty;
    end

    fifo_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && count_q == DEPTH_C));

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: a real-valued pipelined adder stands in for the FP core,
// and a queue-based model predicts grants, responses and busy each cycle.
module tb_fp_add_arbiter;

    localparam int N       = 4;
    localparam int LATENCY = 4;
    localparam int DEPTH   = 8;
    localparam int IDW     = $clog2(N);
    localparam int SW      = N + IDW + 99;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fp_add_arbiter_if #(.N(N), .IDW(IDW)) bus ();

    fp_add_arbiter #(.N(N), .LATENCY(LATENCY), .FIFO_DEPTH(DEPTH), .IDW(IDW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Single-precision helpers via double; operands are small integers so sums are exact.
    function automatic real sp_to_real(input logic [31:0] s);
        logic [63:0] d;
        if (s[30:23] == 8'd0) return 0.0;
        d = {s[31], {3'b000, s[30:23]} + 11'd896, s[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] real_to_sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] int_to_sp(input int v);
        return real_to_sp(real'(v));
    endfunction

    function automatic logic [31:0] sp_add(input logic [31:0] a, input logic [31:0] b);
        return real_to_sp(sp_to_real(a) + sp_to_real(b));
    endfunction

    // Stand-in adder: LATENCY edges from operand capture to result, shares the reset.
    logic [31:0] add_pipe [LATENCY];
    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < LATENCY; k++) add_pipe[k] <= 32'd0;
        end else begin
            add_pipe[0] <= sp_add(bus.adder_a, bus.adder_b);
            for (int k = 1; k < LATENCY; k++) add_pipe[k] <= add_pipe[k-1];
        end
    end
    assign bus.adder_result = add_pipe[LATENCY-1];

    // Reference model: every accepted op waits in one ordered queue until popped.
    typedef struct {
        logic [31:0] sum;
        int          id;
        int          due;
    } op_t;

    op_t          mq[$];
    int           m_rr = 0;
    int           cyc = 0;
    int           m_credits;
    logic [31:0]  op_a [N];
    logic [31:0]  op_b [N];
    logic [SW-1:0] exp_snap;

    function automatic logic [SW-1:0] obs();
        return {bus.req_ready, bus.adder_go, bus.adder_a, bus.adder_b,
                bus.resp_valid, bus.resp_data, bus.resp_id, bus.busy};
    endfunction

    task automatic randomize_ops();
        for (int i = 0; i < N; i++) begin
            op_a[i] = int_to_sp(int'($urandom_range(1, 100000)));
            op_b[i] = int_to_sp(int'($urandom_range(1, 100000)));
        end
    endtask

    task automatic do_reset(input int edges);
        @(negedge clk);
        reset          = 1'b1;
        bus.req_valid  = '0;
        bus.resp_ready = 1'b0;
        repeat (edges) @(posedge clk);
        #1 reset = 1'b0;
        mq.delete();
        m_rr = 0;
        cyc  = 0;
    endtask

    // Drive one cycle, predict this cycle's outputs into exp_snap, then advance the model.
    task automatic apply(input logic [N-1:0] v, input logic r);
        logic           issue, vis, e_busy;
        int             g;
        logic [N-1:0]   e_ready;
        logic [31:0]    e_a, e_b, e_data;
        logic [IDW-1:0] e_id;
        @(negedge clk);
        bus.req_valid  = v;
        bus.resp_ready = r;
        for (int i = 0; i < N; i++) begin
            bus.req_a[32*i +: 32] = op_a[i];
            bus.req_b[32*i +: 32] = op_b[i];
        end
        #1;
        m_credits = DEPTH - mq.size();
        issue     = (v != '0) && (m_credits > 0);
        g = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (v[(m_rr + k) % N]) g = (m_rr + k) % N;
        end
        vis     = (mq.size() > 0) && (mq[0].due <= cyc);
        e_ready = issue ? (N'(1) << g) : '0;
        e_a     = issue ? op_a[g] : 32'd0;
        e_b     = issue ? op_b[g] : 32'd0;
        e_data  = vis ? mq[0].sum : 32'd0;
        e_id    = vis ? IDW'(mq[0].id) : '0;
        e_busy  = (mq.size() > 0);
        exp_snap = {e_ready, issue, e_a, e_b, vis, e_data, e_id, e_busy};
        if (vis && r) void'(mq.pop_front());
        if (issue) begin
            mq.push_back('{sum: sp_add(op_a[g], op_b[g]), id: g, due: cyc + LATENCY + 1});
            m_rr = (g + 1) % N;
        end
        cyc++;
    endtask

    task automatic test_reset();
        do_reset(2);
        randomize_ops();
        apply('0, 1'b0);
        if (obs() !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h expected all zero", obs());
        end
        n_vec++;
        if (dut.credits_q !== 4'd8 || dut.rr_ptr_q !== 2'd0) begin
            n_err++;
            $display("FAIL reset_state: credits %0d rr_ptr %0d, expected 8 and 0", dut.credits_q, dut.rr_ptr_q);
        end
        n_vec++;
    endtask

    task automatic test_single_op();
        do_reset(2);
        randomize_ops();
        op_a[2] = 32'h3F80_0000;
        op_b[2] = 32'h3F80_0000;
        apply(4'b0100, 1'b1);
        if ({bus.req_ready, bus.adder_go} !== 5'b0100_1) begin
            n_err++;
            $display("FAIL single_issue: ready/go %b expected 01001", {bus.req_ready, bus.adder_go});
        end
        n_vec++;
        for (int c = 1; c <= 6; c++) begin
            apply('0, 1'b1);
            if (obs() !== exp_snap) begin
                n_err++;
                $display("FAIL single_model cyc%0d: got %h expected %h", c, obs(), exp_snap);
            end
            n_vec++;
            if (c == 5 && {bus.resp_valid, bus.resp_data, bus.resp_id} !== {1'b1, 32'h4000_0000, 2'd2}) begin
                n_err++;
                $display("FAIL single_resp: valid %b data %h id %0d expected 1 40000000 2",
                         bus.resp_valid, bus.resp_data, bus.resp_id);
            end
            if (c == 5) n_vec++;
            if (c == 6 && bus.busy !== 1'b0) begin
                n_err++;
                $display("FAIL single_busy: busy %b expected 0", bus.busy);
            end
            if (c == 6) n_vec++;
        end
    endtask

    task automatic test_fairness();
        int ids[$];
        do_reset(2);
        for (int c = 0; c < 20; c++) begin
            randomize_ops();
            apply((c < 8) ? 4'b1111 : 4'b0000, 1'b1);
            if (obs() !== exp_snap) begin
                n_err++;
                $display("FAIL fair_model cyc%0d: got %h expected %h", c, obs(), exp_snap);
            end
            n_vec++;
            if (c < 8 && bus.req_ready !== (4'b0001 << (c % 4))) begin
                n_err++;
                $display("FAIL fair_grant cyc%0d: req_ready %b expected %b", c, bus.req_ready, 4'b0001 << (c % 4));
            end
            if (c < 8) n_vec++;
            if (bus.resp_valid === 1'b1) ids.push_back(int'(bus.resp_id));
        end
        if (ids.size() != 8) begin
            n_err++;
            $display("FAIL fair_resp_count: got %0d expected 8", ids.size());
        end
        n_vec++;
        for (int k = 0; k < ids.size(); k++) begin
            if (ids[k] != k % 4) begin
                n_err++;
                $display("FAIL fair_resp_order #%0d: id %0d expected %0d", k, ids[k], k % 4);
            end
            n_vec++;
        end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] want;
        logic         rdy;
        do_reset(2);
        for (int c = 0; c < 15; c++) begin
            randomize_ops();
            rdy  = (c == 12);
            want = (c < 8 || c == 13) ? 4'b0001 : 4'b0000;
            apply(4'b0001, rdy);
            if (bus.req_ready !== want) begin
                n_err++;
                $display("FAIL bp_ready cyc%0d: req_ready %b expected %b", c, bus.req_ready, want);
            end
            n_vec++;
            if (obs() !== exp_snap) begin
                n_err++;
                $display("FAIL bp_model cyc%0d: got %h expected %h", c, obs(), exp_snap);
            end
            n_vec++;
        end
        for (int c = 0; c < 16; c++) begin
            apply('0, 1'b1);
            if (obs() !== exp_snap) begin
                n_err++;
                $display("FAIL bp_drain cyc%0d: got %h expected %h", c, obs(), exp_snap);
            end
            n_vec++;
        end
    endtask

    task automatic test_push_pop();
        do_reset(2);
        for (int c = 0; c < 30; c++) begin
            randomize_ops();
            apply(4'b0010, 1'b1);
            if (obs() !== exp_snap) begin
                n_err++;
                $display("FAIL pp_model cyc%0d: got %h expected %h", c, obs(), exp_snap);
            end
            n_vec++;
            if (c >= 6 && (int'(dut.credits_q) != m_credits || m_credits != 3 || dut.count_q > 4'd1)) begin
                n_err++;
                $display("FAIL pp_steady cyc%0d: credits %0d count %0d expected credits 3 count <=1",
                         c, dut.credits_q, dut.count_q);
            end
            if (c >= 6) n_vec++;
        end
        for (int c = 0; c < 8; c++) apply('0, 1'b1);
    endtask

    task automatic test_reset_midflight();
        do_reset(2);
        for (int c = 0; c < 3; c++) begin
            randomize_ops();
            apply(4'b0001 << c, 1'b1);
        end
        do_reset(1);
        for (int c = 4; c <= 12; c++) begin
            apply('0, 1'b1);
            if (bus.resp_valid !== 1'b0 || obs() !== exp_snap) begin
                n_err++;
                $display("FAIL midreset cyc%0d: got %h expected %h", c, obs(), exp_snap);
            end
            n_vec++;
        end
        if (dut.credits_q !== 4'd8 || dut.rr_ptr_q !== 2'd0) begin
            n_err++;
            $display("FAIL midreset_state: credits %0d rr_ptr %0d expected 8 and 0", dut.credits_q, dut.rr_ptr_q);
        end
        n_vec++;
    endtask

    task automatic test_wrap();
        logic [N-1:0] want [3];
        logic [N-1:0] reqs [3];
        want = '{4'b0100, 4'b0001, 4'b0010};
        reqs = '{4'b0100, 4'b0011, 4'b0011};
        do_reset(2);
        for (int c = 0; c < 3; c++) begin
            randomize_ops();
            apply(reqs[c], 1'b1);
            if (bus.req_ready !== want[c] || obs() !== exp_snap) begin
                n_err++;
                $display("FAIL wrap cyc%0d: req_ready %b expected %b", c, bus.req_ready, want[c]);
            end
            n_vec++;
            if (c == 2 && dut.rr_ptr_q !== 2'd1) begin
                n_err++;
                $display("FAIL wrap_ptr: rr_ptr %0d expected 1", dut.rr_ptr_q);
            end
            if (c == 2) n_vec++;
        end
        for (int c = 0; c < 10; c++) apply('0, 1'b1);
    endtask

    task automatic test_random();
        do_reset(2);
        for (int c = 0; c < 320; c++) begin
            randomize_ops();
            apply((c < 300) ? N'($urandom_range(0, 15)) : '0,
                  (c < 300) ? ($urandom_range(0, 9) < 7) : 1'b1);
            if (obs() !== exp_snap) begin
                n_err++;
                $display("FAIL random cyc%0d: got %h expected %h", c, obs(), exp_snap);
            end
            n_vec++;
        end
    endtask

    initial begin
        bus.req_valid  = '0;
        bus.resp_ready = 1'b0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        test_reset();
        test_single_op();
        test_fairness();
        test_backpressure();
        test_push_pop();
        test_reset_midflight();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
